// File: rtl/ahb_wrap4_read_master.sv
// AHB-Lite read master issuing one WRAP4 word burst per cache-line refill request.
// Beats start at the critical word and wrap within the 16-byte line.
module ahb_wrap4_read_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rdata_offset,
    output logic              done,
    output logic              error
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-5:0]  base;
    logic [1:0]         start;
    logic [1:0]         beat;       // beat currently in its address phase
    logic [1:0]         off;
    logic [1:0]         off_d;      // word index of the beat in its data phase
    logic               dphase;
    logic               addr_done;
    logic               unused_bits;

    assign unused_bits = ^req_addr[1:0];

    assign hwrite       = 1'b0;
    assign hburst       = 3'b010;
    assign hsize        = 3'b010;
    assign rdata        = hrdata;
    assign rdata_offset = off_d;

    assign off       = start + beat;
    assign dphase    = (state == S_BURST) || (state == S_LAST);
    assign addr_done = ((state == S_ADDR) && hready) ||
                       ((state == S_BURST) && hready && !hresp);
    assign haddr     = rst ? '0 : {base, off, 2'b00};

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        htrans      = TR_IDLE;
        done        = 1'b0;
        error       = 1'b0;
        rdata_valid = dphase && hready && !hresp;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                htrans = TR_NONSEQ;
                if (hready) state_nxt = S_BURST;
            end
            S_BURST: begin
                htrans = TR_SEQ;
                if (hresp) begin
                    error     = hready;
                    state_nxt = hready ? S_IDLE : S_ERR;
                end else if (hready && beat == 2'd3) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                if (hresp) begin
                    error     = hready;
                    state_nxt = hready ? S_IDLE : S_ERR;
                end else if (hready) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                // The burst is already aborted; the closing ERROR cycle reports it.
                if (hready) begin
                    error     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) begin
            state_nxt   = S_IDLE;
            req_ready   = 1'b0;
            htrans      = TR_IDLE;
            done        = 1'b0;
            error       = 1'b0;
            rdata_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            base  <= '0;
            start <= '0;
            beat  <= '0;
            off_d <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid) begin
                base  <= req_addr[ADDR_W-1:4];
                start <= req_addr[3:2];
                beat  <= '0;
            end
            if (addr_done) begin
                off_d <= off;
                beat  <= beat + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_wrap4_read_master.sv
// Randomized bench: a reference model expands each accepted request into its four
// wrapped addresses; a monitor scoreboards every cycle against it and a slave model.
module tb_ahb_wrap4_read_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic [1:0]  rdata_offset;
    logic        done;
    logic        error;

    ahb_wrap4_read_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hburst(hburst), .hsize(hsize), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .rdata_valid(rdata_valid), .rdata(rdata),
        .rdata_offset(rdata_offset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // model state, written only by the monitor
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          nwait = 0;
    int          ok_cnt = 0;
    int          last_done = 0;
    bit          busy = 0;
    bit          dphase = 0;
    bit          err2 = 0;
    bit          chain = 0;
    bit          prev_rst = 0;
    logic [31:0] exp_addr[$];
    logic [1:0]  exp_off[$];

    // burst shaping, written only by the request process
    int          wait_pct = 0;
    int          inj_beat = 4;
    bit          viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // slave: random wait states, optional two-cycle ERROR or a one-cycle protocol violation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (err2) begin
                hready = 1'b1;
                hresp  = 1'b1;
            end else if (dphase && ok_cnt == inj_beat) begin
                hready = viol;
                hresp  = 1'b1;
            end else begin
                hresp  = 1'b0;
                hready = ($urandom_range(99) >= wait_pct);
                hrdata = $urandom;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        logic [1:0]  eh;
        logic [31:0] base;
        bit          exp_rv, exp_done, exp_err, nd, busy_cur;
        int unsigned st;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("reset_ctl", 32'({req_ready, rdata_valid, done, error, htrans}), 32'd0);
                check("reset_haddr", haddr, 32'd0);
                exp_addr.delete();
                exp_off.delete();
                busy = 0; dphase = 0; err2 = 0; chain = 0; prev_rst = 1;
                continue;
            end
            busy_cur = busy;
            if (!busy || err2 || exp_addr.size() == 0) eh = 2'b00;
            else if (exp_addr.size() == 4)              eh = 2'b10;
            else                                        eh = 2'b11;
            exp_err  = (dphase || err2) && hready && hresp;
            exp_rv   = dphase && hready && !hresp;
            exp_done = exp_rv && ok_cnt == 3;

            check("req_ready", 32'(req_ready), 32'(!busy));
            check("htrans", 32'(htrans), 32'(eh));
            check("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
            check("done", 32'(done), 32'(exp_done));
            check("error", 32'(error), 32'(exp_err));
            check("const_ctl", 32'({hwrite, hburst, hsize}), 32'({1'b0, 3'b010, 3'b010}));
            if (eh != 2'b00) check("haddr", haddr, exp_addr[0]);
            if (prev_rst) check("haddr_after_rst", haddr, 32'd0);
            prev_rst = 0;
            if (exp_rv && exp_off.size() > 0) begin
                check("rdata_offset", 32'(rdata_offset), 32'(exp_off[0]));
                check("rdata", rdata, hrdata);
                void'(exp_off.pop_front());
            end
            if (done) check("done_cycle", 32'(cyc), 32'(acc_cyc + 5 + nwait));

            if (busy && !hready) nwait++;
            nd = dphase;
            if (exp_err) begin
                busy = 0; nd = 0; err2 = 0;
                exp_addr.delete();
                exp_off.delete();
            end else begin
                if (exp_rv) begin
                    ok_cnt++;
                    nd = 0;
                end
                if (dphase && hresp && !hready) begin
                    err2 = 1; nd = 0;
                    exp_addr.delete();
                end else if (eh != 2'b00 && hready) begin
                    exp_off.push_back(exp_addr[0][3:2]);
                    void'(exp_addr.pop_front());
                    nd = 1;
                end
                if (exp_done) begin
                    busy = 0;
                    last_done = cyc;
                end
            end
            dphase = nd;
            if (exp_done) chain = req_valid;
            else if (!req_valid) chain = 0;

            if (!busy_cur && req_valid) begin
                if (chain) check("accept_gap", 32'(cyc), 32'(last_done + 1));
                base = req_addr & 32'hFFFF_FFF0;
                st   = 32'(req_addr[3:2]);
                for (int i = 0; i < 4; i++) exp_addr.push_back(base | (((st + i) % 4) << 2));
                busy = 1; ok_cnt = 0; nwait = 0; acc_cyc = cyc; chain = 0;
                acc_cnt++;
            end
        end
    end

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target) begin
            @(posedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL accept_timeout: got %0d acceptances want %0d", acc_cnt, target);
                $fatal(1, "acceptance timeout");
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy) begin
            @(posedge clk);
            n++;
            if (n > 500) begin
                $display("FAIL burst_timeout: got busy after %0d cycles want idle", n);
                $fatal(1, "burst timeout");
            end
        end
        #1;
    endtask

    // requests: directed corner cases first, then random kinds
    initial begin
        logic [31:0] dir_addr [6];
        int          kind, target;
        dir_addr[0] = 32'h0000_1008;
        dir_addr[1] = 32'hFFFF_FFFE;
        dir_addr[2] = 32'h0000_2004;
        dir_addr[3] = 32'h0000_300C;
        dir_addr[4] = 32'h0000_4000;
        dir_addr[5] = 32'h0000_5008;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int b = 0; b < 60; b++) begin
            kind     = (b < 6) ? b : $urandom_range(0, 5);
            wait_pct = (kind == 0 || kind == 5 && b < 6) ? 0 : $urandom_range(0, 40);
            if (b == 2) wait_pct = 50;
            viol     = (kind == 3);
            inj_beat = (kind == 2 || kind == 3) ? ((b < 6) ? 2 : $urandom_range(0, 3)) : 4;
            req_addr  = (b < 6) ? dir_addr[b] : $urandom;
            req_valid = 1'b1;
            target = acc_cnt + 1;
            wait_acc(target);
            if (kind == 5) begin
                wait_acc(target + 1);
            end
            req_valid = 1'b0;
            if (kind == 4) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_wrap4_read_master.md
AHB_WRAP4_READ_MASTER -- requirements
Module: ahb_wrap4_read_master

Interface
REQ-001 Parameter: ADDR_W, 32, address width; only 32 is supported.
REQ-002 Parameter: DATA_W, 32, read data width; only 32 is supported.
REQ-003 Port: clk  input  1  single clock; all logic updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: req_valid  input  1  cache-line refill request.
REQ-006 Port: req_ready  output  1  request accepted when high together with req_valid at a clock edge.
REQ-007 Port: req_addr  input  ADDR_W  critical-word address; bits [1:0] are ignored.
REQ-008 Port: haddr  output  ADDR_W  AHB address.
REQ-009 Port: htrans  output  2  AHB transfer type: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
REQ-010 Port: hwrite  output  1  constant 0.
REQ-011 Port: hburst  output  3  constant 3'b010 (WRAP4).
REQ-012 Port: hsize  output  3  constant 3'b010 (word).
REQ-013 Port: hready  input  1  AHB transfer-done / wait-state signal.
REQ-014 Port: hresp  input  1  AHB response: 0 = OKAY, 1 = ERROR.
REQ-015 Port: hrdata  input  DATA_W  AHB read data.
REQ-016 Port: rdata_valid  output  1  one-cycle strobe per beat returned with OKAY.
REQ-017 Port: rdata  output  DATA_W  equals hrdata; meaningful only while rdata_valid is high.
REQ-018 Port: rdata_offset  output  2  word index within the line (haddr[3:2] of the beat).
REQ-019 Port: done  output  1  one-cycle pulse, coincident with the 4th rdata_valid.
REQ-020 Port: error  output  1  one-cycle pulse when a burst is aborted by an ERROR response.

Function
REQ-021 FSM states: IDLE, ADDR (NONSEQ beat 0), BURST (SEQ beats 1-3 overlapping data phases), LAST (data phase of beat 3 only), ERR (waiting for the second cycle of the ERROR response).
REQ-022 req_ready shall be 1 only in IDLE with rst low; requests presented in any other state are ignored.
REQ-023 On acceptance, base = {req_addr[31:4], 4'b0000} and start index = req_addr[3:2] are latched.
REQ-024 Beat i address = base | (((start + i) mod 4) << 2), for i = 0..3; wrap is confined to the 16-byte line and the carry never propagates into bits [31:4].
REQ-025 Cycle T (accept) -> T+1: htrans=NONSEQ with the beat-0 address; T+2..T+4: htrans=SEQ with beats 1-3, given hready=1 throughout.
REQ-026 An address phase completes only at an edge where hready=1; while hready=0, haddr and htrans shall hold unchanged.
REQ-027 A data phase occupies the cycle(s) after its address phase and completes at an edge where hready=1.
REQ-028 rdata_valid = (data phase active) & hready & ~hresp, combinational; rdata_offset is the registered index of that beat.
REQ-029 With zero wait states: rdata_valid in T+2..T+5; done in T+5; htrans=IDLE from T+5; state IDLE and req_ready=1 at T+6.
REQ-030 Each wait cycle delays every subsequent beat, done, and the return to IDLE by exactly one cycle.
REQ-031 hresp=1 with hready=0 in a data phase:
  - no rdata_valid for that beat;
  - next cycle: htrans=IDLE, and the pending address is cancelled;
  - enter ERR.
REQ-032 In ERR, when hready=1 with hresp=1: pulse error, suppress done, and go to IDLE next cycle; beats already delivered remain valid.
REQ-033 hresp=1 together with hready=1 outside ERR (protocol violation) shall be treated as the second cycle of an ERROR response: same outcome as REQ-032.
REQ-034 htrans shall never output BUSY.
REQ-035 done and error shall never be high in the same cycle; each occurs at most once per request.

Reset
REQ-036 While rst is high at an edge: state=IDLE, htrans=IDLE, haddr=0, latched base and index = 0, and rdata_valid, done, error, req_ready all 0.
REQ-037 Reset asserted mid-burst abandons the burst without a done or error pulse; req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-038 req_addr=0x0000_1008, hready=1 -> haddr 0x1008, 0x100C, 0x1000, 0x1004; htrans 10, 11, 11, 11, then 00; rdata_offset 2, 3, 0, 1; done with the 4th rdata_valid at T+5.
REQ-039 req_addr=0xFFFF_FFFE -> haddr 0xFFFF_FFFC, 0xFFFF_FFF0, 0xFFFF_FFF4, 0xFFFF_FFF8; no carry out of bit 31.
REQ-040 hready=0 for 2 cycles during the beat-1 data phase -> haddr/htrans frozen at beat 2 for those cycles; no rdata_valid during them; done at T+7.
REQ-041 hresp=1/hready=0 then hresp=1/hready=1 on the beat-2 data phase -> 2 rdata_valid pulses only; htrans=IDLE next cycle; error pulse; no done; req_ready=1 afterward.
REQ-042 rst=1 for one cycle at T+3 -> all outputs at reset values; req_ready=1 the cycle after; no done.
REQ-043 req_valid held high throughout a burst -> exactly one burst per IDLE acceptance; the next request is accepted at T+6.
